pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central sequencer for the 16-bit, 8-register pipelined processor.
- Generates the advance enables and flush (bubble) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three conditions: load-use hazards, taken branches and multi-cycle data-memory waits.
- Sequences HLT: the pipeline drains, the block parks in a halted state, and `restart` resumes it.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive memory-wait cycles before a fatal timeout.
- WAIT_W, 8: width of the memory-wait counter; must satisfy MEM_TIMEOUT < 2^WAIT_W.
- DRAIN_CYCLES, 3: cycles needed to retire HLT through EX, MEM and WB.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  3  source register of the instruction in ID.
- id_rd  in  3  second operand / destination register of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads id_rs.
- id_uses_rd  in  1  ID instruction reads id_rd.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  3  load destination register in EX.
- branch_taken_ex  in  1  branch resolved taken in EX.
- mem_access_mem  in  1  instruction in MEM is a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- halt_id  in  1  ID holds HLT.
- restart  in  1  resume from HALTED.
- pc_we  out  1  PC update enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (all-zero control) instead of upstream data.
- halted  out  1  block is in HALTED.
- mem_timeout  out  1  sticky fatal error flag.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Control outputs are combinational from state and current inputs. State, counters and flags are registered.
- Reset asserted (reset=0):
  - state=RUN, wait_cnt=0, drain_cnt=0, mem_timeout=0, stall_cycles=0.
  - All enables and flushes forced to 0; halted=0.
  - Reset mid-operation aborts any wait or drain with no residual state.
- Default in RUN: all enables=1, all flushes=0.
- Condition terms:
  - `memstall` = mem_access_mem & !mem_ready.
  - `loaduse` = ex_mem_read & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rd & id_rd==ex_rd)). All 3 bits are compared; r0 is an ordinary register.
- Priority order, highest first:
  1. `memstall`: pc_we, if_id_en, id_ex_en and ex_mem_en = 0; mem_wb_flush = 1. Next state is MEM_WAIT.
  2. `branch_taken_ex`: pc_we=1 (PC loads the target); if_id_flush=1 and id_ex_flush=1. loaduse and halt_id are ignored.
  3. `loaduse`: pc_we=0, if_id_en=0, id_ex_flush=1; EX/MEM and MEM/WB advance. Exactly one bubble per hazard.
  4. `halt_id` with ID advancing: outputs stay at the default; next state DRAIN with drain_cnt = DRAIN_CYCLES.
- MEM_WAIT:
  - Same freeze as `memstall` while mem_ready=0; wait_cnt increments each such cycle.
  - When the next increment would reach MEM_TIMEOUT: set mem_timeout and go to HALTED.
  - On mem_ready=1: outputs as RUN with the same priority order (branch, loaduse, halt), wait_cnt cleared, next state RUN, or DRAIN if the halt rule fires.
- DRAIN:
  - pc_we=0, if_id_en=0, id_ex_flush=1; EX/MEM and MEM/WB advance.
  - drain_cnt decrements each advancing cycle.
  - memstall freezes the pipeline as in MEM_WAIT (drain_cnt holds, wait_cnt and timeout apply); the block stays in DRAIN.
  - branch_taken_ex is ignored in DRAIN; no instruction can be behind HLT.
  - When drain_cnt reaches 0: go to HALTED.
- HALTED:
  - All enables=0, all flushes=0, halted=1.
  - restart=1 moves to RUN next cycle, but only if mem_timeout=0.
  - mem_timeout is cleared only by reset.
- stall_cycles: +1 in every RUN or MEM_WAIT cycle with pc_we=0; saturates at all-ones; never counts in DRAIN or HALTED.

Decomposition:
- Package pipeline_ctrl_pkg:
  - State enum RUN/MEM_WAIT/DRAIN/HALTED (2-bit encoding).
  - REG_ADDR_W=3, DATA_W=16.
  - Default parameter constants.
- Sub-module hazard_detect: purely combinational loaduse comparator (ports id_rs, id_rd, id_uses_*, ex_mem_read, ex_rd -> loaduse).

Test Plan:
- Load to r3 in EX; ID uses_rs with id_rs=3 -> exactly one cycle of pc_we=0, if_id_en=0, id_ex_flush=1; stall_cycles goes 0->1. Same case with id_rs=4 -> no stall.
- loaduse and branch_taken_ex in the same cycle -> pc_we=1, if_id_flush=1, id_ex_flush=1; stall_cycles unchanged.
- mem_access_mem=1 with mem_ready low for 2 cycles -> pc_we, if_id_en, id_ex_en, ex_mem_en held 0 and mem_wb_flush=1 for 2 cycles; third cycle full advance; stall_cycles=2.
- MEM_TIMEOUT=4 with mem_ready stuck low -> mem_timeout=1 and halted=1 after 4 wait cycles; restart ignored.
- halt_id in RUN -> 3 DRAIN cycles of id_ex_flush=1, then halted=1. restart pulse -> RUN next cycle with pc_we=1.
- Reset asserted mid-MEM_WAIT -> all outputs 0 immediately (asynchronous). After release: RUN, counters 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline sequencer of the 16-bit,
// 8-register processor.
//   ctrl_state_t      : sequencer state (RUN / MEM_WAIT / DRAIN / HALTED)
//   REG_ADDR_W        : register-file address width
//   DATA_W            : datapath width
//   DEF_*             : default values for the pipeline_ctrl parameters
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;

  localparam int DEF_MEM_TIMEOUT  = 255;
  localparam int DEF_WAIT_W       = 8;
  localparam int DEF_DRAIN_CYCLES = 3;
  localparam int DEF_CNT_W        = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
// Bundles the hazard/status inputs seen by the pipeline sequencer and the
// pipeline-register controls it produces.
//   master : sequencer side (reads hazard inputs, drives enables/flushes)
//   slave  : datapath side (drives hazard inputs, reads enables/flushes)
// Parameter CNT_W sets the width of the stall_cycles counter.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
) ();
  import pipeline_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_uses_rs;
  logic                  id_uses_rd;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  branch_taken_ex;
  logic                  mem_access_mem;
  logic                  mem_ready;
  logic                  halt_id;
  logic                  restart;

  logic                  pc_we;
  logic                  if_id_en;
  logic                  id_ex_en;
  logic                  ex_mem_en;
  logic                  mem_wb_en;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  mem_wb_flush;
  logic                  halted;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    input  id_rs, id_rd, id_uses_rs, id_uses_rd, ex_mem_read, ex_rd,
           branch_taken_ex, mem_access_mem, mem_ready, halt_id, restart,
    output pc_we, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush,
           halted, mem_timeout, stall_cycles
  );

  modport slave (
    output id_rs, id_rd, id_uses_rs, id_uses_rd, ex_mem_read, ex_rd,
           branch_taken_ex, mem_access_mem, mem_ready, halt_id, restart,
    input  pc_we, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush,
           halted, mem_timeout, stall_cycles
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect
// Combinational load-use comparator: flags when the instruction in ID reads
// the register a load in EX is about to write.
//   id_rs, id_rd           : ID source / second-operand registers
//   id_uses_rs, id_uses_rd : ID actually reads that register
//   ex_mem_read, ex_rd     : EX holds a load writing ex_rd
//   loaduse                : a one-cycle bubble is required
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rd,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  loaduse
);

  // r0 is an ordinary register here, so every address bit takes part in the
  // match and no special case for register 0 exists.
  assign loaduse = ex_mem_read &
                   ((id_uses_rs & (id_rs == ex_rd)) |
                    (id_uses_rd & (id_rd == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central sequencer for the pipelined processor. Produces the PC write enable
// and the load/flush controls of IF/ID, ID/EX, EX/MEM and MEM/WB, resolving
// memory waits, taken branches, load-use hazards and HLT draining.
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : pipeline_ctrl_if.master (hazard inputs in, controls/status out)
// Parameters:
//   MEM_TIMEOUT  : consecutive memory-wait cycles that trigger a fatal timeout
//   WAIT_W       : wait counter width (MEM_TIMEOUT < 2**WAIT_W)
//   DRAIN_CYCLES : cycles to retire HLT through EX, MEM and WB
//   CNT_W        : stall_cycles width
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int WAIT_W       = DEF_WAIT_W,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic            clock,
  input  logic            reset,
  pipeline_ctrl_if.master bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT   = DRAIN_W'(DRAIN_CYCLES);

  ctrl_state_t        state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               timeout_q, timeout_set;
  logic [CNT_W-1:0]   stall_q;
  logic               count_stall;

  logic loaduse, memstall, frozen, wait_expired;
  logic pc_we_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
  logic if_id_flush_c, id_ex_flush_c, mem_wb_flush_c, halted_c;

  hazard_detect u_hazard (
    .id_rs       (bus.id_rs),
    .id_rd       (bus.id_rd),
    .id_uses_rs  (bus.id_uses_rs),
    .id_uses_rd  (bus.id_uses_rd),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .loaduse     (loaduse)
  );

  assign memstall     = bus.mem_access_mem & ~bus.mem_ready;
  assign wait_expired = (wait_q == TIMEOUT_LAST);

  // Once parked in MEM_WAIT, only mem_ready releases the freeze; elsewhere a
  // fresh memory stall is needed to freeze the pipe.
  always_comb begin
    frozen = 1'b0;
    case (state_q)
      RUN:      frozen = memstall;
      MEM_WAIT: frozen = ~bus.mem_ready;
      DRAIN:    frozen = memstall;
      default:  frozen = 1'b0;
    endcase
  end

  // Next-state and control outputs. A freeze holds PC through EX/MEM and
  // feeds a bubble into MEM/WB; the wait counter runs on every frozen cycle
  // and forces HALTED with a sticky timeout when it would hit MEM_TIMEOUT.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    drain_d        = drain_q;
    timeout_set    = 1'b0;
    count_stall    = 1'b0;
    pc_we_c        = 1'b1;
    if_id_en_c     = 1'b1;
    id_ex_en_c     = 1'b1;
    ex_mem_en_c    = 1'b1;
    mem_wb_en_c    = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    mem_wb_flush_c = 1'b0;
    halted_c       = 1'b0;

    if (frozen) begin
      pc_we_c        = 1'b0;
      if_id_en_c     = 1'b0;
      id_ex_en_c     = 1'b0;
      ex_mem_en_c    = 1'b0;
      mem_wb_flush_c = 1'b1;
      if (state_q != DRAIN) begin
        state_d = MEM_WAIT;
      end
      if (wait_expired) begin
        timeout_set = 1'b1;
        state_d     = HALTED;
        wait_d      = '0;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end

    case (state_q)
      RUN, MEM_WAIT: begin
        if (!frozen) begin
          wait_d  = '0;
          state_d = RUN;
          if (bus.branch_taken_ex) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (loaduse) begin
            pc_we_c       = 1'b0;
            if_id_en_c    = 1'b0;
            id_ex_flush_c = 1'b1;
          end else if (bus.halt_id) begin
            state_d = DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
        count_stall = ~pc_we_c;
      end
      DRAIN: begin
        // Nothing valid follows HLT, so a branch in EX is ignored here.
        if (!frozen) begin
          pc_we_c       = 1'b0;
          if_id_en_c    = 1'b0;
          id_ex_flush_c = 1'b1;
          wait_d        = '0;
          drain_d       = drain_q - 1'b1;
          if (drain_q <= 1) begin
            state_d = HALTED;
          end
        end
      end
      default: begin
        pc_we_c        = 1'b0;
        if_id_en_c     = 1'b0;
        id_ex_en_c     = 1'b0;
        ex_mem_en_c    = 1'b0;
        mem_wb_en_c    = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        mem_wb_flush_c = 1'b0;
        halted_c       = 1'b1;
        if (bus.restart && !timeout_q) begin
          state_d = RUN;
        end
      end
    endcase
  end

  // State, counters and the sticky timeout flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      drain_q   <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
      if (count_stall && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  // Reset is asynchronous, so the combinational controls are gated by it
  // directly to drop to zero the moment reset asserts.
  assign bus.pc_we        = reset & pc_we_c;
  assign bus.if_id_en     = reset & if_id_en_c;
  assign bus.id_ex_en     = reset & id_ex_en_c;
  assign bus.ex_mem_en    = reset & ex_mem_en_c;
  assign bus.mem_wb_en    = reset & mem_wb_en_c;
  assign bus.if_id_flush  = reset & if_id_flush_c;
  assign bus.id_ex_flush  = reset & id_ex_flush_c;
  assign bus.mem_wb_flush = reset & mem_wb_flush_c;
  assign bus.halted       = reset & halted_c;
  assign bus.mem_timeout  = timeout_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the sequencing rules.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int MEM_TIMEOUT  = 4;
  localparam int WAIT_W       = 8;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .WAIT_W       (WAIT_W),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Model state: halted flag, waiting-on-memory flag, remaining drain cycles
  // (0 = not draining), consecutive wait cycles, sticky timeout, stall count.
  bit m_halted, m_waiting, m_timeout;
  int m_drain, m_wait, m_stalls;

  typedef struct packed {
    logic pc_we, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush, halted;
  } ctl_t;

  function automatic bit isLoadUse();
    return bus.ex_mem_read &&
           ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
            (bus.id_uses_rd && bus.id_rd == bus.ex_rd));
  endfunction

  function automatic bit isFrozen();
    if (m_waiting && m_drain == 0) return !bus.mem_ready;
    return bus.mem_access_mem && !bus.mem_ready;
  endfunction

  function automatic ctl_t modelCtl();
    ctl_t e;
    e = '0;
    if (!reset) return e;
    if (m_halted) begin
      e.halted = 1'b1;
      return e;
    end
    e.pc_we = 1'b1; e.if_id_en = 1'b1; e.id_ex_en = 1'b1;
    e.ex_mem_en = 1'b1; e.mem_wb_en = 1'b1;
    if (isFrozen()) begin
      e.pc_we = 1'b0; e.if_id_en = 1'b0; e.id_ex_en = 1'b0;
      e.ex_mem_en = 1'b0; e.mem_wb_flush = 1'b1;
    end else if (m_drain > 0 || (!bus.branch_taken_ex && isLoadUse())) begin
      e.pc_we = 1'b0; e.if_id_en = 1'b0; e.id_ex_flush = 1'b1;
    end else if (bus.branch_taken_ex) begin
      e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
    end
    return e;
  endfunction

  task automatic modelReset();
    m_halted = 0; m_waiting = 0; m_timeout = 0;
    m_drain = 0; m_wait = 0; m_stalls = 0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic modelStep();
    ctl_t e;
    e = modelCtl();
    if (!reset) return;
    if (m_halted) begin
      if (bus.restart && !m_timeout) m_halted = 0;
      return;
    end
    if (m_drain == 0 && !e.pc_we)
      m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
    if (isFrozen()) begin
      m_wait++;
      if (m_wait >= MEM_TIMEOUT) begin
        m_timeout = 1; m_halted = 1; m_drain = 0; m_waiting = 0; m_wait = 0;
      end else if (m_drain == 0) begin
        m_waiting = 1;
      end
    end else begin
      m_wait = 0;
      m_waiting = 0;
      if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end else if (!bus.branch_taken_ex && !isLoadUse() && bus.halt_id) begin
        m_drain = DRAIN_CYCLES;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel(input string tag);
    ctl_t e;
    e = modelCtl();
    checkOutput({tag, ".pc_we"},        int'(bus.pc_we),        int'(e.pc_we));
    checkOutput({tag, ".if_id_en"},     int'(bus.if_id_en),     int'(e.if_id_en));
    checkOutput({tag, ".id_ex_en"},     int'(bus.id_ex_en),     int'(e.id_ex_en));
    checkOutput({tag, ".ex_mem_en"},    int'(bus.ex_mem_en),    int'(e.ex_mem_en));
    checkOutput({tag, ".mem_wb_en"},    int'(bus.mem_wb_en),    int'(e.mem_wb_en));
    checkOutput({tag, ".if_id_flush"},  int'(bus.if_id_flush),  int'(e.if_id_flush));
    checkOutput({tag, ".id_ex_flush"},  int'(bus.id_ex_flush),  int'(e.id_ex_flush));
    checkOutput({tag, ".mem_wb_flush"}, int'(bus.mem_wb_flush), int'(e.mem_wb_flush));
    checkOutput({tag, ".halted"},       int'(bus.halted),       int'(e.halted));
    checkOutput({tag, ".mem_timeout"},  int'(bus.mem_timeout),  int'(m_timeout));
    checkOutput({tag, ".stall_cycles"}, int'(bus.stall_cycles), m_stalls);
  endtask

  // Drive all inputs (called just after a falling edge), then let them settle.
  task automatic applyStimulus(
    input logic [2:0] rs, input logic [2:0] rd,
    input logic urs, input logic urd,
    input logic exr, input logic [2:0] exrd,
    input logic br, input logic macc, input logic rdy,
    input logic hlt, input logic rst);
    bus.id_rs = rs; bus.id_rd = rd;
    bus.id_uses_rs = urs; bus.id_uses_rd = urd;
    bus.ex_mem_read = exr; bus.ex_rd = exrd;
    bus.branch_taken_ex = br; bus.mem_access_mem = macc;
    bus.mem_ready = rdy; bus.halt_id = hlt; bus.restart = rst;
    #2;
  endtask

  task automatic idle();
    applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic tick(input string tag);
    compareModel(tag);
    modelStep();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    modelReset();
    compareModel("reset");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    $display("[TB] pipeline_ctrl bench start");
    applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    doReset();

    // Reset state and a clean advancing cycle.
    idle();
    checkOutput("rst_stall", int'(bus.stall_cycles), 0);
    checkOutput("rst_pc_we", int'(bus.pc_we), 1);
    tick("idle0");

    // Load into r3 in EX while ID reads r3: one bubble.
    applyStimulus(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_pc_we", int'(bus.pc_we), 0);
    checkOutput("lu_if_id_en", int'(bus.if_id_en), 0);
    checkOutput("lu_id_ex_flush", int'(bus.id_ex_flush), 1);
    tick("lu");
    idle();
    checkOutput("lu_stall", int'(bus.stall_cycles), 1);
    checkOutput("lu_after_pc_we", int'(bus.pc_we), 1);
    tick("lu_after");

    // Same load, ID reads r4: no hazard.
    applyStimulus(3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("nolu_pc_we", int'(bus.pc_we), 1);
    tick("nolu");

    // Branch outranks load-use.
    applyStimulus(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("br_pc_we", int'(bus.pc_we), 1);
    checkOutput("br_if_id_flush", int'(bus.if_id_flush), 1);
    checkOutput("br_id_ex_flush", int'(bus.id_ex_flush), 1);
    tick("br");
    idle();
    checkOutput("br_stall", int'(bus.stall_cycles), 1);
    tick("br_after");

    // Two-cycle memory wait.
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("mw_pc_we", int'(bus.pc_we), 0);
      checkOutput("mw_ex_mem_en", int'(bus.ex_mem_en), 0);
      checkOutput("mw_mem_wb_flush", int'(bus.mem_wb_flush), 1);
      tick("mw");
    end
    applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("mw_done_pc_we", int'(bus.pc_we), 1);
    checkOutput("mw_done_ex_mem_en", int'(bus.ex_mem_en), 1);
    checkOutput("mw_stall", int'(bus.stall_cycles), 2);
    tick("mw_done");

    // Memory never answers: timeout after MEM_TIMEOUT wait cycles.
    doReset();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("to_pending", int'(bus.mem_timeout), 0);
      tick("to_wait");
    end
    applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("to_flag", int'(bus.mem_timeout), 1);
    checkOutput("to_halted", int'(bus.halted), 1);
    tick("to_restart");
    idle();
    checkOutput("to_restart_ignored", int'(bus.halted), 1);
    tick("to_after");

    // HLT drains for DRAIN_CYCLES, parks, then restarts.
    doReset();
    applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("hlt_pc_we", int'(bus.pc_we), 1);
    tick("hlt");
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      idle();
      checkOutput("drain_id_ex_flush", int'(bus.id_ex_flush), 1);
      checkOutput("drain_pc_we", int'(bus.pc_we), 0);
      tick("drain");
    end
    idle();
    checkOutput("hlt_halted", int'(bus.halted), 1);
    tick("parked");
    applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick("restart");
    idle();
    checkOutput("resume_pc_we", int'(bus.pc_we), 1);
    checkOutput("resume_halted", int'(bus.halted), 0);
    checkOutput("resume_stall", int'(bus.stall_cycles), 0);
    tick("resume");

    // Sustained load-use saturates the stall counter.
    doReset();
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      applyStimulus(3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick("sat");
    end
    idle();
    checkOutput("sat_stall", int'(bus.stall_cycles), CNT_MAX);
    tick("sat_after");

    // Asynchronous reset in the middle of a memory wait.
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick("pre_rst");
    end
    applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("arst_mem_wb_flush", int'(bus.mem_wb_flush), 0);
    checkOutput("arst_mem_wb_en", int'(bus.mem_wb_en), 0);
    checkOutput("arst_stall", int'(bus.stall_cycles), 0);
    modelReset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle();
    checkOutput("arst_after_pc_we", int'(bus.pc_we), 1);
    tick("arst_after");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (m_timeout && $urandom_range(0, 3) == 0) doReset();
      applyStimulus(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 99) < 30), 3'($urandom_range(0, 3)),
                    1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 40),
                    1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 5),
                    1'($urandom_range(0, 99) < 20));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
